// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI serial transmitter and its matching receiver:
// FSM state encoding and the default frame width.
package nrzi_pkg;

  localparam int NRZI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } nrzi_state_t;

endpackage

// File: rtl/nrzi_serial_tx_if.sv
// Word handshake and coded serial line of the NRZI transmitter.
// The master modport is the word producer and line observer; the slave modport is the transmitter.
interface nrzi_serial_tx_if
  import nrzi_pkg::*;
#(
  parameter int WIDTH = NRZI_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             line_out;
  logic             bit_valid;
  logic             done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  line_out,
    input  bit_valid,
    input  done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output line_out,
    output bit_valid,
    output done
  );

endinterface

// File: rtl/nrzi_serial_tx.sv
// NRZI serial transmitter: accepts a word over valid/ready, sends one sync slot at the
// current line level, then WIDTH data slots LSB-first where a 1 toggles the line.
module nrzi_serial_tx
  import nrzi_pkg::*;
#(
  parameter int   WIDTH      = NRZI_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             reset,
  nrzi_serial_tx_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  nrzi_state_t      state_q;
  nrzi_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             line_q;
  logic             done_q;

  logic             ready_c;
  logic             bit_valid_c;
  logic             last_slot;
  logic             accept;
  logic             advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter names the data slot currently on the line; ready is only raised in
  // the final slot so a waiting word chains into the next SYNC without a gap.
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    bit_valid_c = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    last_slot   = (state_q == SHIFT) && (cnt_q == LAST);
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.data_valid) begin
          accept  = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        bit_valid_c = 1'b1;
        advance     = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        bit_valid_c = 1'b1;
        if (last_slot) begin
          ready_c = 1'b1;
          if (bus.data_valid) begin
            accept  = 1'b1;
            state_d = SYNC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line is updated on the edge that enters each data slot, so bit k is on the
  // line for the whole of slot k and the level simply holds once the frame ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      line_q  <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_slot;
      if (accept) begin
        shreg_q <= bus.data_in;
        cnt_q   <= '0;
      end else if (advance) begin
        line_q  <= line_q ^ shreg_q[0];
        shreg_q <= shreg_q >> 1;
        if (state_q == SHIFT) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.data_ready = ready_c;
  assign bus.bit_valid  = bit_valid_c;
  assign bus.line_out   = line_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_nrzi_serial_tx.sv
// Randomized and directed bench for nrzi_serial_tx against a slot-level frame model
// and a behavioural transition-detector receiver fed from line_out.
module tb_nrzi_serial_tx;

  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;

  logic clk;
  logic reset;

  nrzi_serial_tx_if #(.WIDTH(W)) bus ();

  nrzi_serial_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int test_count = 0;
  int fail_count = 0;

  // Model: slot 0 is sync, slot s (1..W) shows data bit s-1; line = ref ^ parity of sent bits.
  bit          mdl_busy  = 1'b0;
  int unsigned mdl_word  = 0;
  int          mdl_slot  = 0;
  logic        mdl_ref   = IDLE;
  logic        mdl_level = IDLE;
  logic        mdl_done  = 1'b0;
  bit          mdl_hs    = 1'b0;
  int unsigned sent[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_line();
    if (!mdl_busy) return mdl_level;
    return mdl_ref ^ (^(mdl_word & ((32'd1 << mdl_slot) - 32'd1)));
  endfunction

  function automatic logic model_ready();
    return !mdl_busy || (mdl_slot == W);
  endfunction

  task automatic modelStep();
    logic cur_line;
    logic next_done;
    cur_line  = model_line();
    next_done = mdl_busy && (mdl_slot == W);
    mdl_hs    = bus.data_valid && model_ready();
    if (mdl_hs) begin
      mdl_busy = 1'b1;
      mdl_word = 32'(bus.data_in);
      mdl_ref  = cur_line;
      mdl_slot = 0;
      sent.push_back(32'(bus.data_in));
    end else if (mdl_busy && mdl_slot < W) begin
      mdl_slot++;
    end else begin
      mdl_level = cur_line;
      mdl_busy  = 1'b0;
    end
    mdl_done = next_done;
  endtask

  task automatic modelReset();
    mdl_busy  = 1'b0;
    mdl_slot  = 0;
    mdl_level = IDLE;
    mdl_done  = 1'b0;
    mdl_hs    = 1'b0;
    sent.delete();
  endtask

  task automatic checkCycle();
    checkOutput("line_out",   32'(bus.line_out),   32'(model_line()));
    checkOutput("bit_valid",  32'(bus.bit_valid),  32'(mdl_busy));
    checkOutput("data_ready", 32'(bus.data_ready), 32'(model_ready()));
    checkOutput("done",       32'(bus.done),       32'(mdl_done));
  endtask

  task automatic applyStimulus(input logic valid, input logic [W-1:0] data);
    bus.data_valid = valid;
    bus.data_in    = data;
    @(posedge clk);
    modelStep();
    #1;
    checkCycle();
  endtask

  // Receiver: first valid slot of a frame is the reference, then each level change is a 1.
  initial begin
    int         rx_idx;
    logic       rx_prev;
    logic [W-1:0] rx_word;
    rx_idx  = 0;
    rx_prev = IDLE;
    rx_word = '0;
    forever begin
      @(negedge clk);
      if (reset || !bus.bit_valid) begin
        rx_idx = 0;
      end else if (rx_idx == 0) begin
        rx_prev = bus.line_out;
        rx_word = '0;
        rx_idx  = 1;
      end else begin
        rx_word[rx_idx-1] = bus.line_out ^ rx_prev;
        rx_prev           = bus.line_out;
        if (rx_idx == W) begin
          if (sent.size() > 0) checkOutput("rx_word", 32'(rx_word), sent.pop_front());
          else                 checkOutput("rx_unexpected", 32'(rx_word), 32'hFFFF_FFFF);
          rx_idx = 0;
        end else begin
          rx_idx++;
        end
      end
    end
  end

  initial begin
    int          tries;
    int          gap;
    logic [W-1:0] w;
    reset          = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_line",  32'(bus.line_out),   32'(IDLE));
    checkOutput("rst_valid", 32'(bus.bit_valid),  32'd0);
    checkOutput("rst_done",  32'(bus.done),       32'd0);
    checkOutput("rst_ready", 32'(bus.data_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    checkCycle();
    repeat (5) applyStimulus(1'b0, W'($urandom));

    $display("[TB] single frame 8'h1D");
    applyStimulus(1'b1, 8'h1D);
    repeat (W + 3) applyStimulus(1'b0, 8'h00);

    $display("[TB] back-to-back 8'hFF then 8'h00");
    applyStimulus(1'b1, 8'hFF);
    repeat (W + 1) applyStimulus(1'b1, 8'h00);
    checkOutput("b2b_hs_final_slot", 32'(mdl_hs), 32'd1);
    checkOutput("b2b_done_with_sync", 32'(bus.done), 32'd1);
    repeat (W + 3) applyStimulus(1'b0, 8'h00);

    $display("[TB] busy rejection with 8'hAA");
    applyStimulus(1'b1, 8'h3C);
    repeat (W + 1) applyStimulus(1'b1, 8'hAA);
    repeat (W + 3) applyStimulus(1'b0, 8'h55);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h0F);
    repeat (4) applyStimulus(1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_line",  32'(bus.line_out),   32'(IDLE));
    checkOutput("midrst_valid", 32'(bus.bit_valid),  32'd0);
    checkOutput("midrst_done",  32'(bus.done),       32'd0);
    checkOutput("midrst_ready", 32'(bus.data_ready), 32'd1);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkCycle();
    applyStimulus(1'b1, 8'h0F);
    repeat (W + 3) applyStimulus(1'b0, 8'h00);

    $display("[TB] random loopback words");
    for (int i = 0; i < 10; i++) begin
      w   = W'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) applyStimulus(1'b0, W'($urandom));
      tries = 0;
      do begin
        applyStimulus(1'b1, w);
        tries++;
      end while (!mdl_hs && tries < 4 * W);
      if (!mdl_hs) checkOutput("hs_timeout", 32'd0, 32'd1);
    end
    repeat (W + 4) applyStimulus(1'b0, 8'h00);
    checkOutput("rx_pending", 32'(sent.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/nrzi_serial_tx.md
# nrzi_serial_tx

Serial transmitter that takes a parallel word over a valid/ready handshake and drives it LSB-first onto a single line using transition (NRZI-style) coding: a 1 bit toggles the line, a 0 bit holds it. Each frame starts with one sync cycle that presents the current line level as a reference. The block is the sending end for the team's serial transition-detector receiver FSM, which recovers the bit stream by flagging level changes. It also generates stimulus for that receiver in system benches.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- IDLE_LEVEL, 1'b0, line level after reset

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- data_in  in  WIDTH  word to send, sampled on handshake
- data_valid  in  1  word available
- data_ready  out  1  block can accept a word this cycle
- line_out  out  1  coded serial line, registered
- bit_valid  out  1  line_out carries a sync or data slot this cycle
- done  out  1  one-cycle pulse after the last data bit of a frame

## Operation
- States: IDLE, SYNC, SHIFT.
- IDLE: data_ready=1, bit_valid=0, line_out holds its level. On data_valid&&data_ready, load the shift register with data_in, clear the bit counter, and go to SYNC.
- SYNC (1 cycle): bit_valid=1 and line_out unchanged. The receiver treats this as the reference level. Next state is SHIFT.
- SHIFT (WIDTH cycles): each edge sets line_out <= line_out ^ shreg[0], shifts shreg right, and increments the counter, with bit_valid=1.
- data_ready is also 1 during the final SHIFT cycle (counter==WIDTH-1).
  - If a handshake occurs then, the next frame loads and the block goes directly to SYNC with no idle gap.
  - Otherwise the block goes to IDLE.
- data_ready=0 in SYNC and in non-final SHIFT cycles. data_valid is ignored there and data_in is not sampled.
- done is registered and asserts in the cycle after the final data bit, concurrent with IDLE or with the next frame's SYNC.
- line_out never returns to IDLE_LEVEL between frames. Only reset restores it.
- Counter width is $clog2(WIDTH). No wrap is reachable because the counter clears on every load.

## Timing
- Reset values: line_out=IDLE_LEVEL, data_ready=1 (IDLE), bit_valid=0, done=0, state=IDLE, shreg=0, counter=0.
- Handshake at edge E0 gives:
  - SYNC slot visible after E0.
  - Data bit k visible after edge E(k+1), for k=0..WIDTH-1.
  - done high after E(WIDTH+1).
- Frame occupancy is WIDTH+1 cycles. Back-to-back throughput is one word per WIDTH+1 cycles.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to reset values. The partial frame is dropped and no done is issued.
- Reset release: the first handshake is possible at the first rising edge after deassertion.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Package nrzi_pkg holds the state typedef (IDLE, SYNC, SHIFT as a 2-bit enum) and the default WIDTH constant shared with the receiver.
- Single module with no sub-modules. The shift register, counter and FSM are small enough to stay flat.

## Test plan
- Reset with WIDTH=8: reset high for 2 cycles, then low. Expect line_out=0, bit_valid=0, done=0, data_ready=1. No activity for 5 idle cycles.
- Single frame 8'h1D from line level 0, bits LSB-first 1,0,1,1,1,0,0,0:
  - SYNC: line_out=0.
  - Data slots: line_out=1,1,0,1,0,0,0,0.
  - bit_valid high for 9 cycles, then done pulses once.
- Back-to-back 8'hFF then 8'h00, with data_valid held:
  - Second handshake lands in the final SHIFT cycle.
  - First frame toggles the line every data slot (8 toggles, ending at 0).
  - Second SYNC follows with no gap; second frame holds 0.
  - done is high in the same cycle as the second SYNC.
- Busy rejection: data_valid=1 with data_in=8'hAA during SYNC and mid-SHIFT. Expect data_ready=0 and the current frame unaffected; 8'hAA is sent only after the final-slot handshake.
- Reset mid-frame: reset after data bit 3 of 8'h0F. Expect line_out=IDLE_LEVEL and bit_valid=0 immediately, no done pulse, and a fresh 8'h0F frame sent correctly afterwards.
- Receiver loopback: drive line_out into the transition-detector receiver. On 10 random words, the recovered flags match the transmitted data bits.
